// File: rtl/vga_pixel_aligner_pkg.sv
// Shared types and default timing for the VGA pixel aligner slice.
//   pixel_t       : 4-bit-per-channel RGB pixel
//   align_state_e : frame-lock FSM states
//   pipe_word_t   : one delay-line word {pixel, hsync, vsync, de, frame_start}
//   DEF_*         : default geometry / pipeline constants
package vga_pixel_aligner_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        UNLOCKED,
        SYNCING,
        LOCKED
    } align_state_e;

    typedef struct packed {
        pixel_t pix;
        logic   hs;
        logic   vs;
        logic   de;
        logic   fs;
    } pipe_word_t;

    localparam int unsigned DEF_PIPE_STAGES = 2;
    localparam int unsigned DEF_H_ACTIVE    = 640;
    localparam int unsigned DEF_V_ACTIVE    = 480;
    localparam bit          DEF_SYNC_POL    = 1'b0;

endpackage

// File: rtl/vga_pixel_aligner_if.sv
// Video stream bundle between the colour filter chain and the VGA pins.
//   *_in  : filtered pixel, syncs and active-video enable (from the filter chain)
//   *_out : aligned, gated pixel and delayed syncs (to the pins)
//   frame_start / locked : status towards capture/debug logic
// Modports: master = stream source/sink side, slave = the aligner.
interface vga_pixel_aligner_if;

    logic [3:0] R_in;
    logic [3:0] G_in;
    logic [3:0] B_in;
    logic       hsync_in;
    logic       vsync_in;
    logic       de_in;

    logic [3:0] R_out;
    logic [3:0] G_out;
    logic [3:0] B_out;
    logic       hsync_out;
    logic       vsync_out;
    logic       de_out;
    logic       frame_start;
    logic       locked;

    modport master (
        output R_in, G_in, B_in, hsync_in, vsync_in, de_in,
        input  R_out, G_out, B_out, hsync_out, vsync_out, de_out, frame_start, locked
    );

    modport slave (
        input  R_in, G_in, B_in, hsync_in, vsync_in, de_in,
        output R_out, G_out, B_out, hsync_out, vsync_out, de_out, frame_start, locked
    );

endinterface

// File: rtl/vga_pixel_aligner_delay_line.sv
// delay_line: fixed-depth shift register with synchronous reset.
//   clk  : clock
//   rst  : synchronous active-high reset; every stage loads RST_VAL
//   din  : word entering the line
//   dout : word after DEPTH clock edges
module delay_line #(
    parameter int unsigned      WIDTH   = 1,
    parameter int unsigned      DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int unsigned SW = WIDTH * DEPTH;

    // Stages packed into one vector; newest word in the low slice.
    logic [SW-1:0] sr;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr <= {DEPTH{RST_VAL}};
        end else begin
            sr <= SW'({sr, din});
        end
    end

    assign dout = sr[SW-1 -: WIDTH];

endmodule

// File: rtl/vga_pixel_aligner.sv
// vga_pixel_aligner: output stage in front of the VGA pins.
// Delays syncs/de/pixel by PIPE_STAGES cycles, blanks RGB unless the input
// geometry is locked, and emits a frame_start pulse with pixel (0,0).
//   clk : pixel clock
//   rst : synchronous active-high reset
//   vif : video stream bundle (slave modport)
// Optional build macro: BORDER_OVERLAY_EN - paint frame border pixels white.
module vga_pixel_aligner
    import vga_pixel_aligner_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = DEF_PIPE_STAGES,
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter bit          SYNC_POL    = DEF_SYNC_POL
) (
    input logic                clk,
    input logic                rst,
    vga_pixel_aligner_if.slave vif
);

    localparam int unsigned XW = $clog2(H_ACTIVE + 1);
    localparam int unsigned YW = $clog2(V_ACTIVE + 1);
    localparam logic [XW-1:0] X_FULL = XW'(H_ACTIVE);
    localparam logic [YW-1:0] Y_FULL = YW'(V_ACTIVE);
`ifdef BORDER_OVERLAY_EN
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
`endif
    localparam pipe_word_t RST_WORD = '{pix: '0, hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, fs: 1'b0};

    align_state_e state, state_nxt;

    // x counts pixels already seen on this line (= index of the current one);
    // y counts completed lines since the last vsync edge.
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          de_d, vs_d, bad_seen;
    logic          vs_edge, de_fall, line_bad, frame_ok, is_locked;
    pixel_t        pix_gated;
    pipe_word_t    word_in, word_out;

    assign vs_edge   = (vif.vsync_in == SYNC_POL) && (vs_d != SYNC_POL);
    assign de_fall   = de_d && !vif.de_in;
    // A full line leaves x == H_ACTIVE at the falling edge; any further
    // de_in cycle after that is an over-long line.
    assign line_bad  = (de_fall && (x != X_FULL)) || (vif.de_in && (x == X_FULL));
    assign frame_ok  = (y == Y_FULL) && !bad_seen && !line_bad;
    assign is_locked = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= UNLOCKED;
            x        <= '0;
            y        <= '0;
            de_d     <= 1'b0;
            vs_d     <= ~SYNC_POL;
            bad_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            de_d  <= vif.de_in;
            vs_d  <= vif.vsync_in;

            if (vif.de_in) begin
                if (x != X_FULL) x <= x + 1'b1;
            end else if (de_fall) begin
                x <= '0;
            end

            if (vs_edge) begin
                y <= '0;
            end else if (de_fall && (y != Y_FULL)) begin
                y <= y + 1'b1;
            end

            if (vs_edge) begin
                bad_seen <= 1'b0;
            end else if (line_bad) begin
                bad_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED: if (vs_edge) state_nxt = SYNCING;
            SYNCING:  if (vs_edge && frame_ok) state_nxt = LOCKED;
            LOCKED:   if (line_bad || (vs_edge && !frame_ok)) state_nxt = UNLOCKED;
            default:  state_nxt = UNLOCKED;
        endcase
    end

    always_comb begin
        pix_gated = '0;
        if (vif.de_in && is_locked) begin
            pix_gated = '{r: vif.R_in, g: vif.G_in, b: vif.B_in};
`ifdef BORDER_OVERLAY_EN
            if ((x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST)) begin
                pix_gated = '{r: 4'hF, g: 4'hF, b: 4'hF};
            end
`endif
        end
    end

    always_comb begin
        word_in     = RST_WORD;
        word_in.pix = pix_gated;
        word_in.hs  = vif.hsync_in;
        word_in.vs  = vif.vsync_in;
        word_in.de  = vif.de_in;
        word_in.fs  = vif.de_in && is_locked && (x == '0) && (y == '0);
    end

    delay_line #(
        .WIDTH   ($bits(pipe_word_t)),
        .DEPTH   (PIPE_STAGES),
        .RST_VAL (RST_WORD)
    ) u_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (word_in),
        .dout (word_out)
    );

    assign vif.R_out       = word_out.pix.r;
    assign vif.G_out       = word_out.pix.g;
    assign vif.B_out       = word_out.pix.b;
    assign vif.hsync_out   = word_out.hs;
    assign vif.vsync_out   = word_out.vs;
    assign vif.de_out      = word_out.de;
    assign vif.frame_start = word_out.fs;
    assign vif.locked      = is_locked;

endmodule

// File: tb/tb_vga_pixel_aligner.sv
// Testbench for vga_pixel_aligner (H_ACTIVE=8, V_ACTIVE=4, PIPE_STAGES=2,
// SYNC_POL=0). Builds a cycle-by-cycle stimulus list of whole frames,
// plays it, then checks the captured outputs against a frame-level model
// and against hand-derived expectations for the lock/reset/overlay cases.
`timescale 1ns/1ps
module tb_vga_pixel_aligner;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int PIPE = 2;
    localparam bit SP   = 1'b0;
`ifdef BORDER_OVERLAY_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [3:0] r, g, b;
        logic       hs, vs, de;
    } stim_t;

    typedef struct packed {
        logic [3:0] r, g, b;
        logic       hs, vs, de, fs, lk;
    } obs_t;

    typedef struct {
        logic [3:0] r, g, b;
        logic       hs;
        obs_t       exp;
    } vec_t;

    typedef enum {M_UNL, M_SYN, M_LCK} mst_e;

    localparam obs_t RSTOBS = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: 1'b1, vs: 1'b1,
                                de: 1'b0, fs: 1'b0, lk: 1'b0};

    logic clk = 1'b0;
    logic rst;
    vga_pixel_aligner_if vif();

    vga_pixel_aligner #(
        .PIPE_STAGES (PIPE),
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SYNC_POL    (SP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .vif (vif)
    );

    always #5 clk = ~clk;

    stim_t stim[$];
    obs_t  cap[];
    obs_t  expv[];
    int    fr_ve[16];
    int    fr_ls[16][4];
    int    nfr   = 0;
    int    tests = 0;
    int    fails = 0;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic push(input logic rs, input logic [3:0] r, input logic [3:0] g,
                        input logic [3:0] b, input logic hs, input logic vs, input logic de);
        stim_t s;
        s.rst = rs; s.r = r; s.g = g; s.b = b; s.hs = hs; s.vs = vs; s.de = de;
        stim.push_back(s);
    endtask

    task automatic blank(input int n, input logic hs, input logic vs);
        for (int i = 0; i < n; i++) push(1'b0, 4'h0, 4'h0, 4'h0, hs, vs, 1'b0);
    endtask

    // Frame: vsync pulse, back porch, V lines (hsync, porch, pixels, porch), front porch.
    task automatic add_frame(input int bad_line, input int bad_len, input bit rnd,
                             input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        int len, ex;
        ex = rnd ? int'($urandom_range(0, 3)) : 0;
        fr_ve[nfr] = stim.size();
        blank(3, 1'b1, 1'b0);
        blank(2 + ex, 1'b1, 1'b1);
        for (int l = 0; l < V; l++) begin
            blank(2, 1'b0, 1'b1);
            blank(2, 1'b1, 1'b1);
            fr_ls[nfr][l] = stim.size();
            len = (l == bad_line) ? bad_len : H;
            for (int p = 0; p < len; p++) begin
                if (rnd) push(1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 1'b1, 1'b1, 1'b1);
                else     push(1'b0, r, g, b, 1'b1, 1'b1, 1'b1);
            end
            blank(2 + ex, 1'b1, 1'b1);
        end
        blank(2, 1'b1, 1'b1);
        nfr++;
    endtask

    // Reference: walks the stimulus, measuring line lengths and line counts
    // per frame, and derives the expected output stream and lock status.
    task automatic build_expect();
        int   n = stim.size();
        obs_t word[];
        bit   lka[];
        mst_e st = M_UNL;
        int   run = 0, lines = 0, src;
        bit   clean = 1'b1, pde = 1'b0, pvs = 1'b1, in_rst;
        word = new[n];
        lka  = new[n];
        for (int j = 0; j < n; j++) begin
            if (stim[j].rst) begin
                word[j] = RSTOBS;
                st = M_UNL; run = 0; lines = 0; clean = 1'b1; pde = 1'b0; pvs = 1'b1;
            end else begin
                bit   vedge, fall, bad, fok, lk, border;
                obs_t w;
                vedge = (stim[j].vs == SP) && (pvs != SP);
                fall  = pde && !stim[j].de;
                bad   = (stim[j].de && run >= H) || (fall && run != H);
                fok   = (lines >= V) && clean && !bad;
                lk    = (st == M_LCK);
                w     = RSTOBS;
                w.hs  = stim[j].hs;
                w.vs  = stim[j].vs;
                w.de  = stim[j].de;
                if (stim[j].de && lk) begin
                    border = (run == 0) || (run == H - 1) || (lines == 0) || (lines == V - 1);
                    if (OVL && border) begin
                        w.r = 4'hF; w.g = 4'hF; w.b = 4'hF;
                    end else begin
                        w.r = stim[j].r; w.g = stim[j].g; w.b = stim[j].b;
                    end
                    w.fs = (run == 0) && (lines == 0);
                end
                word[j] = w;
                case (st)
                    M_UNL:   if (vedge) st = M_SYN;
                    M_SYN:   if (vedge && fok) st = M_LCK;
                    default: if (bad || (vedge && !fok)) st = M_UNL;
                endcase
                if (bad) clean = 1'b0;
                if (vedge) clean = 1'b1;
                run = stim[j].de ? run + 1 : 0;
                if (vedge) lines = 0;
                else if (fall) lines++;
                pde = stim[j].de;
                pvs = stim[j].vs;
            end
            lka[j] = (st == M_LCK);
        end
        expv = new[n];
        for (int k = 0; k < n; k++) begin
            src    = k - PIPE + 1;
            in_rst = (src < 0);
            for (int m = (src < 0) ? 0 : src; m <= k; m++) if (stim[m].rst) in_rst = 1'b1;
            expv[k]    = in_rst ? RSTOBS : word[src];
            expv[k].lk = lka[k];
        end
    endtask

    function automatic vec_t mkvec(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                                   input logic hs, input logic exp_hs);
        vec_t v;
        v.r = r; v.g = g; v.b = b; v.hs = hs;
        v.exp = '{r: 4'h0, g: 4'h0, b: 4'h0, hs: exp_hs, vs: 1'b1, de: 1'b0, fs: 1'b0, lk: 1'b1};
        return v;
    endfunction

    initial begin
        vec_t tbl[6];
        int   tl[6] = '{0, 1, 1, 1, 2, 3};
        int   tx[6] = '{3, 0, 7, 3, 5, 4};
        bit   tbd[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        int   tbl_base, p, q, f, r, cnt, bl, blen;
        logic [11:0] rgb;

        tbl[0] = mkvec(4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
        tbl[1] = mkvec(4'hF, 4'hF, 4'hF, 1'b1, 1'b1);
        tbl[2] = mkvec(4'hA, 4'h5, 4'hC, 1'b0, 1'b0);
        tbl[3] = mkvec(4'h1, 4'h2, 4'h3, 1'b1, 1'b1);
        tbl[4] = mkvec(4'hF, 4'h0, 4'hF, 1'b1, 1'b1);
        tbl[5] = mkvec(4'h0, 4'hF, 4'h0, 1'b0, 1'b0);

        rst = 1'b1;
        vif.R_in = 4'h0; vif.G_in = 4'h0; vif.B_in = 4'h0;
        vif.hsync_in = 1'b1; vif.vsync_in = 1'b1; vif.de_in = 1'b0;

        for (int i = 0; i < 3; i++) push(1'b1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) add_frame(-1, 0, 1'b0, 4'h5, 4'hA, 4'h3);   // F0..F2
        tbl_base = stim.size();
        for (int i = 0; i < 6; i++) push(1'b0, tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].hs, 1'b1, 1'b0);
        add_frame(-1, 0, 1'b0, 4'h5, 4'hA, 4'h3);                                // F3
        add_frame(1, 7, 1'b0, 4'h5, 4'hA, 4'h3);                                 // F4 short line
        add_frame(-1, 0, 1'b0, 4'h5, 4'hA, 4'h3);                                // F5
        add_frame(-1, 0, 1'b0, 4'h2, 4'h2, 4'h2);                                // F6 overlay
        add_frame(-1, 0, 1'b0, 4'h1, 4'h2, 4'h3);                                // F7 reset
        stim[fr_ls[7][2] + 3].rst = 1'b1;
        for (int i = 0; i < 3; i++) add_frame(-1, 0, 1'b0, 4'h7, 4'h8, 4'h9);   // F8..F10
        for (int i = 0; i < 5; i++) begin                                        // F11..F15
            bl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : -1;
            case ($urandom_range(0, 2))
                0:       blen = 6;
                1:       blen = 7;
                default: blen = 9;
            endcase
            add_frame(bl, blen, 1'b1, 4'h0, 4'h0, 4'h0);
        end

        cap = new[stim.size()];
        for (int k = 0; k < stim.size(); k++) begin
            @(negedge clk);
            rst          = stim[k].rst;
            vif.R_in     = stim[k].r;
            vif.G_in     = stim[k].g;
            vif.B_in     = stim[k].b;
            vif.hsync_in = stim[k].hs;
            vif.vsync_in = stim[k].vs;
            vif.de_in    = stim[k].de;
            @(posedge clk);
            #1;
            cap[k] = '{r: vif.R_out, g: vif.G_out, b: vif.B_out, hs: vif.hsync_out,
                       vs: vif.vsync_out, de: vif.de_out, fs: vif.frame_start, lk: vif.locked};
        end

        build_expect();
        for (int k = 0; k < stim.size(); k++)
            chk($sformatf("model_cyc%0d", k), int'(cap[k]), int'(expv[k]));

        // Reset state and first lock
        chk("reset_state", int'(cap[0]), int'(RSTOBS));
        chk("t1_syncing_unlocked", int'(cap[fr_ve[0]].lk), 0);
        chk("t1_pre_lock", int'(cap[fr_ve[1] - 1].lk), 0);
        chk("t1_lock_rise", int'(cap[fr_ve[1]].lk), 1);
        q = fr_ls[2][1];
        chk("t1_latency_early", int'(cap[q + PIPE - 2].de), 0);
        chk("t1_latency_de", int'(cap[q + PIPE - 1].de), 1);
        p = q + 3;
        chk("t1_rgb", int'({cap[p + PIPE - 1].r, cap[p + PIPE - 1].g, cap[p + PIPE - 1].b}), 'h5A3);

        // Blanking table while locked
        for (int i = 0; i < 6; i++)
            chk($sformatf("t2_vec%0d", i), int'(cap[tbl_base + i + PIPE - 1]), int'(tbl[i].exp));

        // One frame_start per locked frame, on the first de_out of line 0
        for (int fr = 1; fr <= 3; fr++) begin
            cnt = 0;
            for (int k = fr_ve[fr]; k < fr_ve[fr + 1]; k++) cnt += int'(cap[k].fs);
            chk($sformatf("t5_fs_count_f%0d", fr), cnt, 1);
            chk($sformatf("t5_fs_pos_f%0d", fr),
                int'({cap[fr_ls[fr][0] + PIPE - 1].fs, cap[fr_ls[fr][0] + PIPE - 1].de}), 3);
        end

        // Short line drops lock; black until two clean vsync edges
        f = fr_ls[4][1] + 7;
        chk("t3_locked_before", int'(cap[f - 1].lk), 1);
        chk("t3_unlock", int'(cap[f].lk), 0);
        chk("t3_syncing", int'(cap[fr_ve[5]].lk), 0);
        chk("t3_pre_relock", int'(cap[fr_ve[6] - 1].lk), 0);
        chk("t3_relock", int'(cap[fr_ve[6]].lk), 1);
        cnt = 0;
        for (int k = f + PIPE - 1; k <= fr_ve[6] + PIPE - 1; k++)
            if ({cap[k].r, cap[k].g, cap[k].b} != 12'h000) cnt++;
        chk("t3_black_count", cnt, 0);

        // Border overlay in locked frame F6
        for (int i = 0; i < 6; i++) begin
            p   = fr_ls[6][tl[i]] + tx[i] + PIPE - 1;
            rgb = (OVL && tbd[i]) ? 12'hFFF : 12'h222;
            chk($sformatf("t6_px_y%0d_x%0d", tl[i], tx[i]),
                int'({cap[p].r, cap[p].g, cap[p].b}), int'(rgb));
        end

        // Reset pulse mid-frame at x=3, y=2
        r = fr_ls[7][2] + 3;
        chk("t4_locked_before", int'(cap[r - 1].lk), 1);
        chk("t4_reset_outputs", int'(cap[r]), int'(RSTOBS));
        chk("t4_syncing_after", int'(cap[fr_ve[8]].lk), 0);
        chk("t4_relock", int'(cap[fr_ve[9]].lk), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
